// File: rtl/vx_tensor_wgmma_sequencer_pkg.sv
// Shared tensor-core types: sequencer FSM state and the per-micro-op
// metadata record that also feeds the tensor core's commit metadata queue.
package VX_gpu_pkg;

  localparam int UUID_WIDTH  = 16;
  localparam int NW_WIDTH    = 2;
  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int NR_BITS     = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } tensor_seq_state_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]  uuid;
    logic [NW_WIDTH-1:0]    wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [XLEN-1:0]        pc;
    logic                   wb;
    logic [NR_BITS-1:0]     rd;
  } tensor_uop_meta_t;

endpackage

// File: rtl/vx_tensor_wgmma_sequencer_credit.sv
// Credit counter for in-flight micro-ops. Starts full; take consumes one
// credit, give returns one. Simultaneous give and take cancel out. The
// counter saturates at both ends rather than wrapping.
module VX_tensor_seq_credit #(
  parameter int CREDITS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic give_i,
  input  logic take_i,
  output logic full_o,
  output logic empty_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  logic [CW-1:0] count_q;

  assign full_o  = (count_q == CMAX);
  assign empty_o = (count_q == {CW{1'b0}});

  // Credit count: +1 on give, -1 on take, hold when both or neither
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= CMAX;
    end else begin
      case ({give_i, take_i})
        2'b10:   if (!full_o)  count_q <= count_q + CW'(1);
        2'b01:   if (!empty_o) count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vx_tensor_wgmma_sequencer.sv
// WGMMA micro-op sequencer: accepts one instruction and expands it into
// in_nsteps_m1+1 per-k-step micro-ops, one per cycle at most.
// Optional feature macro: VX_TENSOR_SEQ_CREDIT_EN caps in-flight micro-ops
// at CREDITS so the tensor core's metadata queue cannot overflow.
module vx_tensor_wgmma_sequencer
  import VX_gpu_pkg::*;
#(
  parameter int NUM_STEPS_MAX = 8,
  parameter int CREDITS       = 2,
  parameter int STEPW         = $clog2(NUM_STEPS_MAX)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [UUID_WIDTH-1:0]  in_uuid,
  input  logic [NW_WIDTH-1:0]    in_wid,
  input  logic [NUM_THREADS-1:0] in_tmask,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   in_wb,
  input  logic [NR_BITS-1:0]     in_rd,
  input  logic [STEPW-1:0]       in_nsteps_m1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [UUID_WIDTH-1:0]  out_uuid,
  output logic [NW_WIDTH-1:0]    out_wid,
  output logic [NUM_THREADS-1:0] out_tmask,
  output logic [XLEN-1:0]        out_pc,
  output logic                   out_wb,
  output logic [NR_BITS-1:0]     out_rd,
  output logic [STEPW-1:0]       out_step,
  output logic                   out_last,
  input  logic                   commit_fire,
  output logic                   busy
);

  tensor_seq_state_t state_q;
  logic [STEPW-1:0]  step_q;
  logic [STEPW-1:0]  last_step_q;
  tensor_uop_meta_t  meta_q;

  logic issue_s;
  logic credit_ok_s;
  logic out_fire_s;
  logic accept_s;

  assign issue_s    = (state_q == ISSUE);
  assign in_ready   = (state_q == IDLE);
  assign accept_s   = in_valid & in_ready;
  assign out_valid  = issue_s & credit_ok_s;
  assign out_fire_s = out_valid & out_ready;

  // Everything below is decoded from registers only, so it stays stable
  // while a micro-op is held under backpressure.
  assign out_step  = step_q;
  assign out_last  = issue_s & (step_q == last_step_q);
  assign out_wb    = meta_q.wb & out_last;
  assign out_uuid  = meta_q.uuid;
  assign out_wid   = meta_q.wid;
  assign out_tmask = meta_q.tmask;
  assign out_pc    = meta_q.pc;
  assign out_rd    = meta_q.rd;

  // Sequencer FSM: latch on accept, step on each fire, return to IDLE after the last
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      step_q      <= {STEPW{1'b0}};
      last_step_q <= {STEPW{1'b0}};
      meta_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q     <= ISSUE;
            step_q      <= {STEPW{1'b0}};
            last_step_q <= in_nsteps_m1;
            meta_q      <= '{uuid: in_uuid, wid: in_wid, tmask: in_tmask,
                             pc: in_pc, wb: in_wb, rd: in_rd};
          end
        end
        ISSUE: begin
          if (out_fire_s) begin
            if (step_q == last_step_q) begin
              state_q <= IDLE;
            end else begin
              step_q <= step_q + STEPW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VX_TENSOR_SEQ_CREDIT_EN
  logic credit_full_s;
  logic credit_empty_s;

  VX_tensor_seq_credit #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk     (clk),
    .reset   (reset),
    .give_i  (commit_fire),
    .take_i  (out_fire_s),
    .full_o  (credit_full_s),
    .empty_o (credit_empty_s)
  );

  assign credit_ok_s = ~credit_empty_s;
  assign busy        = issue_s | ~credit_full_s;
`else
  // Without credits the tensor core's commit handshake has no effect here.
  logic unused_cfg_s;
  assign unused_cfg_s = ^{commit_fire, 32'(CREDITS)};
  assign credit_ok_s  = 1'b1;
  assign busy         = issue_s;
`endif

endmodule

// File: tb/tb_vx_tensor_wgmma_sequencer.sv
// Randomized self-checking bench for vx_tensor_wgmma_sequencer. A
// transaction-level model (active instruction, step index, credit count)
// predicts every output; directed phases cover the listed scenarios.
module tb_vx_tensor_wgmma_sequencer;
  import VX_gpu_pkg::*;

  localparam int NSM = 8;
  localparam int CR  = 2;
  localparam int SW  = $clog2(NSM);
`ifdef VX_TENSOR_SEQ_CREDIT_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                   in_valid, in_ready, in_wb, out_valid, out_ready;
  logic [UUID_WIDTH-1:0]  in_uuid, out_uuid;
  logic [NW_WIDTH-1:0]    in_wid, out_wid;
  logic [NUM_THREADS-1:0] in_tmask, out_tmask;
  logic [XLEN-1:0]        in_pc, out_pc;
  logic [NR_BITS-1:0]     in_rd, out_rd;
  logic [SW-1:0]          in_nsteps_m1, out_step;
  logic                   out_wb, out_last, commit_fire, busy;

  vx_tensor_wgmma_sequencer #(.NUM_STEPS_MAX(NSM), .CREDITS(CR)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid),
    .in_wid(in_wid), .in_tmask(in_tmask), .in_pc(in_pc), .in_wb(in_wb),
    .in_rd(in_rd), .in_nsteps_m1(in_nsteps_m1),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid),
    .out_wid(out_wid), .out_tmask(out_tmask), .out_pc(out_pc),
    .out_wb(out_wb), .out_rd(out_rd), .out_step(out_step),
    .out_last(out_last), .commit_fire(commit_fire), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit               m_active = 1'b0;
  int               m_step = 0;
  int               m_last = 0;
  int               m_cred = CR;
  int               n_fire = 0;
  tensor_uop_meta_t m_meta = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    return m_active && (!CEN || m_cred > 0);
  endfunction

  task automatic check_outs();
    bit last;
    last = (m_step == m_last);
    chk("in_ready", in_ready, !m_active);
    chk("out_valid", out_valid, m_valid());
    chk("busy", busy, m_active || (m_cred != CR));
    if (m_valid()) begin
      chk("out_step", out_step, m_step);
      chk("out_last", out_last, last);
      chk("out_wb", out_wb, m_meta.wb && last);
      chk("out_uuid", out_uuid, m_meta.uuid);
      chk("out_wid", out_wid, m_meta.wid);
      chk("out_tmask", out_tmask, m_meta.tmask);
      chk("out_pc", out_pc, m_meta.pc);
      chk("out_rd", out_rd, m_meta.rd);
    end
  endtask

  task automatic model_update();
    bit fire, acc;
    fire = m_valid() && out_ready;
    acc  = in_valid && !m_active;
    if (fire) begin
      n_fire++;
      if (m_step == m_last) m_active = 1'b0;
      else m_step++;
    end
    if (acc) begin
      m_active = 1'b1;
      m_step   = 0;
      m_last   = int'(in_nsteps_m1);
      m_meta   = '{uuid: in_uuid, wid: in_wid, tmask: in_tmask,
                   pc: in_pc, wb: in_wb, rd: in_rd};
    end
    if (CEN) m_cred = m_cred + (commit_fire ? 1 : 0) - (fire ? 1 : 0);
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    check_outs();
    @(posedge clk);
    if (reset) model_update();
    @(negedge clk);
  endtask

  // commit_fire is only raised while a credit is outstanding in credit mode.
  task automatic drive(input bit v, input int nm1, input bit rdy, input bit cf);
    in_valid     = v;
    in_nsteps_m1 = SW'(nm1);
    out_ready    = rdy;
    commit_fire  = cf && (!CEN || m_cred < CR);
    in_uuid      = UUID_WIDTH'($urandom);
    in_wid       = '0;
    in_tmask     = NUM_THREADS'($urandom);
    in_pc        = $urandom;
    in_wb        = 1'($urandom);
    in_rd        = NR_BITS'($urandom);
  endtask

  initial begin
    int f0;
    bit reached;

    drive(1'b0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_step", out_step, 0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_wb", out_wb, 1'b0);
    chk("rst_out_uuid", out_uuid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Single instruction of 4 steps, ready held high
    f0 = n_fire;
    drive(1'b1, 3, 1'b1, 1'b1); tick();
    drive(1'b0, 0, 1'b1, 1'b1); repeat (7) tick();
    chk("t1_fires", n_fire - f0, 4);

    // Backpressure held for 5 cycles at step 1
    drive(1'b1, 3, 1'b1, 1'b1); tick();
    drive(1'b0, 0, 1'b1, 1'b1); tick();
    drive(1'b0, 0, 1'b0, 1'b1); repeat (5) tick();
    drive(1'b0, 0, 1'b1, 1'b1); repeat (7) tick();

`ifdef VX_TENSOR_SEQ_CREDIT_EN
    // Credit stall: 5 steps, no commits -> only CR issue
    drive(1'b0, 0, 1'b1, 1'b1); repeat (4) tick();
    drive(1'b1, 4, 1'b1, 1'b0); tick();
    f0 = n_fire;
    drive(1'b0, 0, 1'b1, 1'b0); repeat (6) tick();
    chk("cr_stall_fires", n_fire - f0, CR);
    chk("cr_stall_valid", out_valid, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b1); tick();
    drive(1'b0, 0, 1'b1, 1'b0); repeat (3) tick();
    chk("cr_release_fires", n_fire - f0, CR + 1);
    drive(1'b0, 0, 1'b1, 1'b1); repeat (8) tick();
`endif

    // Async reset in the middle of an 8-step instruction
    drive(1'b1, 7, 1'b1, 1'b1); tick();
    drive(1'b0, 0, 1'b1, 1'b1);
    reached = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (m_valid() && m_step == 2) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    chk("t4_reach_step2", reached, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t4_async_valid", out_valid, 1'b0);
    chk("t4_async_ready", in_ready, 1'b1);
    chk("t4_async_busy", busy, 1'b0);
    chk("t4_async_step", out_step, 0);
    m_active = 1'b0; m_step = 0; m_last = 0; m_cred = CR;
    @(negedge clk);
    drive(1'b0, 0, 1'b1, 1'b0); tick();
    reset = 1'b1;
    drive(1'b1, 2, 1'b1, 1'b1); tick();
    chk("t4_restart_step", out_step, 0);
    drive(1'b0, 0, 1'b1, 1'b1); repeat (5) tick();

    // Boundary counts: single step, then the maximum
    f0 = n_fire;
    drive(1'b1, 0, 1'b1, 1'b1); tick();
    drive(1'b0, 0, 1'b1, 1'b1); repeat (3) tick();
    chk("t5_single_fires", n_fire - f0, 1);
    f0 = n_fire;
    drive(1'b1, NSM - 1, 1'b1, 1'b1); tick();
    drive(1'b0, 0, 1'b1, 1'b1); repeat (12) tick();
    chk("t5_max_fires", n_fire - f0, NSM);

    // Randomized traffic
    repeat (500) begin
      drive(1'($urandom), int'($urandom_range(NSM - 1, 0)),
            ($urandom_range(3, 0) != 0), 1'($urandom));
      tick();
    end
    drive(1'b0, 0, 1'b1, 1'b1); repeat (30) tick();
    chk("final_idle", in_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_tensor_wgmma_sequencer.md
# vx_tensor_wgmma_sequencer

Upstream micro-op sequencer for the Hopper-style tensor core block. It accepts one WGMMA instruction from the tensor dispatch path and expands it into a stream of per-k-step micro-ops. The stream drives the tensor core's execute interface. With credits enabled, the number of micro-ops in flight is capped to match the depth of the tensor core's commit metadata queue, so that queue can never overflow.

## Interface
- `NUM_STEPS_MAX`, default 8: maximum micro-ops per instruction; must be a power of two and ≥2.
- `CREDITS`, default 2: in-flight micro-op limit; equals the tensor core metadata queue depth.
- `STEPW`, default `$clog2(NUM_STEPS_MAX)`: derived width of the step field.
- `clk` in 1: clock; all state is on the rising edge.
- `reset` in 1: **asynchronous, active-low** reset.
- `in_valid` in 1: instruction valid.
- `in_ready` out 1: sequencer can accept an instruction.
- `in_uuid` in `UUID_WIDTH`: instruction uuid.
- `in_wid` in `NW_WIDTH`: warp id.
- `in_tmask` in `NUM_THREADS`: thread mask.
- `in_pc` in `XLEN`: PC.
- `in_wb` in 1: instruction writes back.
- `in_rd` in `NR_BITS`: destination register.
- `in_nsteps_m1` in STEPW: micro-op count minus 1.
- `out_valid` out 1: micro-op valid.
- `out_ready` in 1: tensor core accepts the micro-op.
- `out_uuid`, `out_wid`, `out_tmask`, `out_pc`, `out_rd` out (same widths as the inputs): latched instruction fields.
- `out_wb` out 1: `in_wb` AND `out_last`.
- `out_step` out STEPW: index of the current micro-op.
- `out_last` out 1: current micro-op is the final step.
- `commit_fire` in 1: tensor core commit handshake fired; returns one credit.
- `busy` out 1: state ≠ IDLE, or any credit is outstanding.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - ISSUE: emitting micro-ops.
- IDLE → ISSUE on `in_valid && in_ready`:
  - Latch all `in_*` fields into the instruction register.
  - Set `step_q`=0 and `last_step_q`=`in_nsteps_m1`.
- In ISSUE:
  - `out_step`=`step_q`.
  - `out_last`=(`step_q`==`last_step_q`).
  - All other `out_*` fields come from the latched register; `out_wb` is asserted only on the last micro-op.
- On an out fire (`out_valid && out_ready`):
  - If not last, `step_q` increments by 1.
  - If last, the FSM returns to IDLE.
- `step_q` never wraps, because `last_step_q` ≤ `NUM_STEPS_MAX`-1.
- `in_wid` ≠ 0 while `in_valid` is high triggers a `RUNTIME_ASSERT` (the tensor core commits only warp 0). The instruction is still sequenced.
- `in_valid` while the FSM is busy is not accepted; `in_ready`=0.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_step`=0, `out_last`=0, `out_wb`=0, all latched fields 0, `busy`=0, credit counter = `CREDITS`.
- Reset may assert at any time, including mid-instruction. Pending micro-ops are discarded; no partial state survives.
- The first micro-op is valid in the cycle after the accept. The sequencer issues at most 1 micro-op per cycle.
- N micro-ops take N cycles with `out_ready` held high. There is one IDLE bubble cycle before the next accept, so back-to-back instructions have period N+1.
- Outputs hold stable while `out_valid && !out_ready`; valid is never dropped without a fire.
- `commit_fire` takes effect on the next edge; there is no combinational path from `commit_fire` to `out_valid`.

## Configuration
- `VX_TENSOR_SEQ_CREDIT_EN` defined:
  - Credit counter `credits_q` of width `$clog2(CREDITS+1)`.
  - `out_valid` = ISSUE && `credits_q`≠0.
  - An out fire decrements the counter; `commit_fire` increments it.
  - Both events in the same cycle leave the count unchanged.
  - `commit_fire` with `credits_q`==`CREDITS` triggers a `RUNTIME_ASSERT`; the counter saturates.
  - `busy` includes `credits_q`≠`CREDITS`.
- Macro undefined:
  - `out_valid` = ISSUE.
  - `commit_fire` is `UNUSED`.
  - `busy` = state≠IDLE.

## Structure
- Put the following in `VX_gpu_pkg`:
  - The `tensor_seq_state_t` enum (IDLE, ISSUE).
  - The `tensor_uop_meta_t` packed struct (uuid, wid, tmask, PC, wb, rd), shared with the tensor core's metadata queue.
- One sub-module, `VX_tensor_seq_credit`: a credit counter with give/take/full/empty. It is instantiated only under `VX_TENSOR_SEQ_CREDIT_EN`.

## Test plan
- Single instruction, credits off: `in_nsteps_m1`=3, `out_ready`=1 → 4 consecutive micro-ops with `out_step` 0,1,2,3. `out_last` and `out_wb`=1 only on step 3. `in_ready` returns high one cycle after the step-3 fire.
- Backpressure: `out_ready` low for 5 cycles at step 1 → `out_valid` and all fields are held constant, then step 2 follows.
- Credits on, `CREDITS`=2, `in_nsteps_m1`=4, no `commit_fire` → exactly 2 micro-ops issue, then `out_valid`=0. A single `commit_fire` releases exactly 1 more micro-op.
- Same-cycle credit return: a fire coinciding with `commit_fire` at `credits_q`=1 → the count stays 1 and issue continues unstalled.
- Async reset asserted at step 2 of 8 → `out_valid`=0 immediately, `in_ready`=1, and credits equal `CREDITS` after release. A new instruction then starts at step 0.
- Boundary counts: `in_nsteps_m1`=0 gives one micro-op with `out_last`=1. `in_nsteps_m1`=`NUM_STEPS_MAX`-1 gives 8 micro-ops with no wrap.
